bcd_serial_addsub: RTL and testbench
====================================

Name: bcd_serial_addsub

Overview:
Parametrised, digit-serial BCD adder/subtractor that generalises the two-digit combinational BCD adder to DIGITS decimal digits.
- Supports an add/subtract mode and a start/busy/done handshake.
- Processes one BCD digit per clock, least-significant digit first, through a single shared digit adder with decimal correction.
- Reports overflow/underflow and invalid-digit conditions.
- Sits between the switch-input capture logic and the seven-segment display decoders.

Parameters:
DIGITS, 4, number of BCD digits per operand and result (minimum 1).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request operation; sampled only in IDLE
op  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start
a  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
b  input  4*DIGITS  operand B, packed BCD
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when result is valid
result  output  4*DIGITS  packed BCD result, held until next accepted start
ovf  output  1  add: carry out of MSD; sub: borrow (a<b); held with result
invalid  output  1  any input digit >9 at capture; held with result
neg  output  1  sign of result (only with SIGNED_MAG_EN; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, ovf=0, invalid=0, neg=0; digit index, carry and operand registers cleared.
- States:
  - IDLE: start=1 captures a, b and op. It also checks every digit of a and b for >9.
    - If any digit is invalid, go to FIN with invalid=1, result=all 4'hF (blank code), ovf=0.
    - Otherwise go to RUN with idx=0. The carry is 0 for add and 1 for sub; for sub, B is nine's-complemented digit-wise (9-d).
  - RUN: each cycle adds a[idx] + b'[idx] + carry in binary (5-bit).
    - If the sum is >9, add 6 and set carry=1; otherwise carry=0.
    - Write result digit idx, then increment idx.
    - When idx==DIGITS-1 is processed, go to FIN.
  - FIN: compute the flag, then set done=1 for one cycle and return to IDLE.
    - Add: ovf = final carry.
    - Sub: ovf = NOT final carry (borrow).
- Latency: start accepted at edge E0. Digits are written on edges E1..E_DIGITS. done is high during the cycle after edge E_(DIGITS+1), i.e. start to done = DIGITS+1 cycles. The invalid path takes 2 cycles.
- busy=1 from the cycle after accept until the cycle done is high (inclusive of RUN; deasserts with done).
- start while busy is ignored. start asserted in the same cycle as done is also ignored; it is accepted only once IDLE is reached.
- Result, ovf and invalid are updated only by a new operation. At accept, the previous result is kept until digits overwrite it; the flags clear at accept.
- Subtraction underflow without the feature: result = ten's complement (10^DIGITS - (b-a)), ovf=1.
- Add overflow: result = low DIGITS digits of the sum (wrap), ovf=1.
- Reset asserted mid-RUN aborts immediately to reset values; no done pulse.
- DIGITS=1: RUN lasts exactly one cycle.

Optional Feature:
SIGNED_MAG_EN
- Defined:
  - A subtract that ends with a borrow enters a second pass, NEGATE. NEGATE runs DIGITS cycles computing b-a with the same datapath (nine's complement of A, carry-in 1).
  - result = magnitude, neg=1, ovf=1, busy held throughout. done arrives 2*DIGITS+1 cycles after accept.
  - A subtract with no borrow gives neg=0; add always gives neg=0.
- Undefined: no NEGATE state; neg is constant 0; behaviour as above.

Test Plan:
- DIGITS=4, add 1234+5678 -> result 6912, ovf=0, invalid=0, done exactly 5 cycles after start accept, busy high 4 cycles before done.
- Add 9999+0001 -> result 0000, ovf=1; add 0905+0095 -> 1000 (carry ripple across three digits), ovf=0.
- Sub 5000-1234 -> 3766, ovf=0; sub 0000-0000 -> 0000, ovf=0.
- Sub 1234-5000:
  - Without feature -> result 6234, ovf=1, neg=0, done at cycle 5.
  - With SIGNED_MAG_EN -> result 3766, neg=1, ovf=1, done at cycle 9.
- a=12A4 (nibble 0xA), b=0001 -> invalid=1, result FFFF, ovf=0, done 2 cycles after accept. A new start with valid inputs clears invalid.
- Mid-operation: start 1234+5678, drop rst_n during the 2nd RUN cycle -> all outputs 0 immediately, no done. Start pulses while busy are ignored, and the operation in flight still yields 6912.

Source files
------------

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: digit-serial BCD adder/subtractor.
// One BCD digit per clock, least-significant digit first, through a single
// shared digit adder with decimal correction. Subtraction adds the nine's
// complement of B with a carry-in of 1 (ten's complement).
// Flags: ovf (add carry-out / subtract borrow), invalid (non-BCD digit seen
// at capture; result is then blanked to all 4'hF).
// Optional build macro SIGNED_MAG_EN: a subtract that borrows runs a second
// NEGATE pass (b - a) so the result is a magnitude with neg=1. When the
// macro is undefined, neg is tied to 0 and there is no NEGATE state.
module bcd_serial_addsub #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                op,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                ovf,
    output logic                invalid,
    output logic                neg
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

`ifdef SIGNED_MAG_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_BLANK  = 3'd2,
        S_FIN    = 3'd3,
        S_NEGATE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_BLANK  = 3'd2,
        S_FIN    = 3'd3
    } state_t;
`endif

    // Nine's complement of one BCD digit.
    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return 4'd9 - d;
    endfunction

    // One decimal digit add: returns {carry_out, corrected_digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       cin);
        logic [4:0] raw;
        raw = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
        if (raw > 5'd9) begin
            return {1'b1, raw[3:0] + 4'd6};
        end else begin
            return {1'b0, raw[3:0]};
        end
    endfunction

    // True when any nibble of a packed BCD word is above 9.
    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    state_t           state_r;
    state_t           state_n_s;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             op_r;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic [W-1:0]     result_r;
    logic             ovf_r;
    logic             invalid_r;
    logic             busy_r;
    logic             done_r;
`ifdef SIGNED_MAG_EN
    logic             negated_r;
    logic             neg_r;
`endif

    logic             accept_s;
    logic             in_bad_s;
    logic             last_s;
    logic [3:0]       a_dig_s;
    logic [3:0]       b_dig_s;
    logic [3:0]       x_s;
    logic [3:0]       y_s;
    logic [4:0]       sum_s;

    // Operand digit selection and the shared decimal digit adder.
    always_comb begin
        in_bad_s = has_bad_digit(a) | has_bad_digit(b);
        last_s   = (idx_r == LAST_IDX);
        a_dig_s  = a_r[{idx_r, 2'b00} +: 4];
        b_dig_s  = b_r[{idx_r, 2'b00} +: 4];
        x_s      = a_dig_s;
        y_s      = b_dig_s;
`ifdef SIGNED_MAG_EN
        if (state_r == S_NEGATE) begin
            // Second pass computes b - a.
            x_s = b_dig_s;
            y_s = nines_comp(a_dig_s);
        end else if (op_r) begin
            y_s = nines_comp(b_dig_s);
        end else begin
            y_s = b_dig_s;
        end
`else
        if (op_r) begin
            y_s = nines_comp(b_dig_s);
        end else begin
            y_s = b_dig_s;
        end
`endif
        sum_s = bcd_digit_add(x_s, y_s, carry_r);
    end

    // Next-state logic and the accept strobe.
    always_comb begin
        state_n_s = state_r;
        accept_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                // A start coinciding with the done pulse is not accepted.
                if (start && !done_r) begin
                    accept_s = 1'b1;
                    if (in_bad_s) begin
                        state_n_s = S_BLANK;
                    end else begin
                        state_n_s = S_RUN;
                    end
                end else begin
                    state_n_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
`ifdef SIGNED_MAG_EN
                    if (op_r && !sum_s[4]) begin
                        state_n_s = S_NEGATE;
                    end else begin
                        state_n_s = S_FIN;
                    end
`else
                    state_n_s = S_FIN;
`endif
                end else begin
                    state_n_s = S_RUN;
                end
            end
`ifdef SIGNED_MAG_EN
            S_NEGATE: begin
                if (last_s) begin
                    state_n_s = S_FIN;
                end else begin
                    state_n_s = S_NEGATE;
                end
            end
`endif
            S_BLANK: state_n_s = S_FIN;
            S_FIN:   state_n_s = S_IDLE;
            default: state_n_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Handshake outputs: done pulses after FIN, busy spans accept..done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= (state_r == S_FIN);
            if (accept_s) begin
                busy_r <= 1'b1;
            end else if (done_r) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Operand capture, digit datapath, result and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= {W{1'b0}};
            b_r       <= {W{1'b0}};
            op_r      <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            carry_r   <= 1'b0;
            result_r  <= {W{1'b0}};
            ovf_r     <= 1'b0;
            invalid_r <= 1'b0;
`ifdef SIGNED_MAG_EN
            negated_r <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else if (accept_s) begin
            a_r       <= a;
            b_r       <= b;
            op_r      <= op;
            idx_r     <= {IDX_W{1'b0}};
            // Ten's complement subtract starts with a carry-in of one.
            carry_r   <= op;
            ovf_r     <= 1'b0;
            invalid_r <= in_bad_s;
`ifdef SIGNED_MAG_EN
            negated_r <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_RUN: begin
                    result_r[{idx_r, 2'b00} +: 4] <= sum_s[3:0];
                    carry_r <= sum_s[4];
                    if (last_s) begin
                        idx_r <= {IDX_W{1'b0}};
`ifdef SIGNED_MAG_EN
                        if (state_n_s == S_NEGATE) begin
                            carry_r   <= 1'b1;
                            negated_r <= 1'b1;
                        end else begin
                            negated_r <= 1'b0;
                        end
`endif
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
`ifdef SIGNED_MAG_EN
                S_NEGATE: begin
                    result_r[{idx_r, 2'b00} +: 4] <= sum_s[3:0];
                    carry_r <= sum_s[4];
                    if (last_s) begin
                        idx_r <= {IDX_W{1'b0}};
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
`endif
                S_BLANK: begin
                    // Blank code for the display decoders.
                    result_r <= {DIGITS{4'hF}};
                end
                S_FIN: begin
                    if (!invalid_r) begin
`ifdef SIGNED_MAG_EN
                        if (negated_r) begin
                            ovf_r <= 1'b1;
                            neg_r <= 1'b1;
                        end else begin
                            ovf_r <= op_r ? ~carry_r : carry_r;
                            neg_r <= 1'b0;
                        end
`else
                        ovf_r <= op_r ? ~carry_r : carry_r;
`endif
                    end else begin
                        ovf_r <= 1'b0;
                    end
                end
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign result  = result_r;
    assign ovf     = ovf_r;
    assign invalid = invalid_r;
`ifdef SIGNED_MAG_EN
    assign neg     = neg_r;
`else
    assign neg     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed testbench for bcd_serial_addsub with DIGITS=4: a vector table of
// operations with hand-computed results, plus hand-written sequences for
// start-while-busy and reset during an operation.
module tb_bcd_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;
    logic        invalid;
    logic        neg;

    int n_cmp;
    int n_err;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf),
        .invalid (invalid),
        .neg     (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        ovf;
        logic        inv;
        logic        neg;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic o, input logic [15:0] av, input logic [15:0] bv,
                                input logic [15:0] r, input logic f, input logic iv,
                                input logic ng, input int l);
        vec_t v;
        v.op = o; v.a = av; v.b = bv; v.res = r;
        v.ovf = f; v.inv = iv; v.neg = ng; v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start one operation, return latency (edges from accept to done),
    // busy-high samples up to done, and post-done handshake state.
    task automatic run_op(input logic op_i, input logic [15:0] a_i, input logic [15:0] b_i,
                          output int lat, output int busy_cnt, output logic after_ok,
                          output logic [1:0] acc_flags);
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        @(posedge clk);
        #1;
        start = 1'b0;
        acc_flags = {ovf, neg};
        lat = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                lat = c;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            after_ok = !busy && !done;
        end else begin
            after_ok = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        int          bcnt;
        logic        aok;
        logic [1:0]  aflags;
        int          seen_done;

        n_cmp = 0;
        n_err = 0;

        vecs[0] = mk(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
        vecs[1] = mk(1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 5);
        vecs[2] = mk(1'b0, 16'h0905, 16'h0095, 16'h1000, 1'b0, 1'b0, 1'b0, 5);
        vecs[3] = mk(1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0, 1'b0, 5);
        vecs[4] = mk(1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5);
`ifdef SIGNED_MAG_EN
        vecs[5] = mk(1'b1, 16'h1234, 16'h5000, 16'h3766, 1'b1, 1'b0, 1'b1, 9);
`else
        vecs[5] = mk(1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b1, 1'b0, 1'b0, 5);
`endif
        vecs[6] = mk(1'b0, 16'h12A4, 16'h0001, 16'hFFFF, 1'b0, 1'b1, 1'b0, 2);
        vecs[7] = mk(1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 5);
`ifdef SIGNED_MAG_EN
        vecs[8] = mk(1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1, 9);
`else
        vecs[8] = mk(1'b1, 16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0, 1'b0, 5);
`endif
        vecs[9] = mk(1'b0, 16'h5555, 16'h4445, 16'h0000, 1'b1, 1'b0, 1'b0, 5);

        // Reset state.
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a = 16'h0000; b = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {26'd0, busy, done, ovf, invalid, neg, 1'b0}, 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven operations.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, aok, aflags);
            check($sformatf("v%0d_result", i), {16'd0, result}, {16'd0, vecs[i].res});
            check($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
            check($sformatf("v%0d_invalid", i), {31'd0, invalid}, {31'd0, vecs[i].inv});
            check($sformatf("v%0d_neg", i), {31'd0, neg}, {31'd0, vecs[i].neg});
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat);
            check($sformatf("v%0d_done_pulse_end", i), {31'd0, aok}, 32'd1);
            check($sformatf("v%0d_flags_clear_at_accept", i), {30'd0, aflags}, 32'd0);
        end

        // Start held high through the whole operation and the done cycle.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h5678;
        @(posedge clk);
        #1;
        op = 1'b1; a = 16'h9999; b = 16'h9999;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        check("busy_start_latency", lat, 5);
        check("busy_start_result", {16'd0, result}, 32'h6912);
        check("busy_start_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_done_cycle_ignored", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("idle_after_ignored_start", {30'd0, busy, done}, 32'd0);

        // Reset during the second RUN cycle.
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_flags", {27'd0, busy, done, ovf, invalid, neg}, 32'd0);
        check("midrun_reset_result", {16'd0, result}, 32'd0);
        seen_done = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("midrun_reset_no_done", seen_done, 0);
        check("midrun_reset_idle", {31'd0, busy}, 32'd0);

        // Valid operation after reset still works.
        run_op(1'b0, 16'h1234, 16'h5678, lat, bcnt, aok, aflags);
        check("post_reset_result", {16'd0, result}, 32'h6912);
        check("post_reset_latency", lat, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
